// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush sequencer with memory-wait timeout trap and stall counter
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int WAIT_W  = 8
) (
  input  logic        clk_HSC,
  input  logic        rst_HSC,
  input  logic [4:0]  Rs1_addr_ID,
  input  logic [4:0]  Rs2_addr_ID,
  input  logic        Rs1_used_ID,
  input  logic        Rs2_used_ID,
  input  logic [4:0]  Rd_addr_EX,
  input  logic        MemRead_EX,
  input  logic        Branch_taken_EX,
  input  logic        DMem_req_Mem,
  input  logic        DMem_ack,
  output logic        en_PC,
  output logic        en_IFID,
  output logic        en_IDEX,
  output logic        en_EXMem,
  output logic        en_MemWB,
  output logic        flush_IFID,
  output logic        flush_IDEX,
  output logic [1:0]  state_out,
  output logic        bus_err,
  output logic [31:0] stall_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2} state_t;
  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              bus_err_q, bus_err_d;
  logic [31:0]       stall_q, stall_d;
  logic              freeze, load_use, go, lu_stall;
  // hazard detection and pipeline enable/flush generation; a branch outranks a load-use stall
  always_comb begin
    freeze     = (state_q == RUN && DMem_req_Mem && !DMem_ack) || (state_q == MEM_WAIT && !DMem_ack) || state_q == ERR;
    load_use   = MemRead_EX && Rd_addr_EX != 5'd0 &&
                 ((Rs1_used_ID && Rs1_addr_ID == Rd_addr_EX) || (Rs2_used_ID && Rs2_addr_ID == Rd_addr_EX));
    go         = !rst_HSC && !freeze;
    lu_stall   = load_use && !Branch_taken_EX;
    en_PC      = go && !lu_stall;
    en_IFID    = go && !lu_stall;
    en_IDEX    = go;
    en_EXMem   = go;
    en_MemWB   = go;
    flush_IFID = go && Branch_taken_EX;
    flush_IDEX = go && (Branch_taken_EX || load_use);
  end
  // memory-wait FSM, timeout trap and stall counting
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    bus_err_d = bus_err_q;
    stall_d   = stall_q + {31'd0, !en_PC};
    if (state_q == RUN && DMem_req_Mem && !DMem_ack) begin
      state_d = MEM_WAIT;
      wait_d  = WAIT_W'(1);
    end else if (state_q == MEM_WAIT) begin
      if (DMem_ack) begin
        state_d = RUN;
        wait_d  = '0;
      end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
        state_d   = ERR;
        bus_err_d = 1'b1;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end
  // state registers with synchronous reset
  always_ff @(posedge clk_HSC) begin
    if (rst_HSC) begin
      state_q   <= RUN;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      stall_q   <= stall_d;
    end
  end
  assign state_out = state_q;
  assign bus_err   = bus_err_q;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed scoreboard bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
  logic        clk = 1'b0;
  logic        rst_HSC;
  logic [4:0]  rs1, rs2, rd;
  logic        u1, u2, mr, br, req, ack;
  logic        en_PC, en_IFID, en_IDEX, en_EXMem, en_MemWB, flush_IFID, flush_IDEX, bus_err;
  logic [1:0]  state_out;
  logic [31:0] stall_cnt;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_stall = 0;
  localparam logic [6:0] NORM = 7'b11111_00;
  localparam logic [6:0] LU   = 7'b00111_01;
  localparam logic [6:0] BR   = 7'b11111_11;
  localparam logic [6:0] FRZ  = 7'b00000_00;
  typedef struct {
    logic [6:0]  ctrl;
    logic [1:0]  st;
    logic        err;
    logic [31:0] stall;
    string       tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.TIMEOUT(16), .WAIT_W(8)) dut (
    .clk_HSC(clk), .rst_HSC(rst_HSC),
    .Rs1_addr_ID(rs1), .Rs2_addr_ID(rs2), .Rs1_used_ID(u1), .Rs2_used_ID(u2),
    .Rd_addr_EX(rd), .MemRead_EX(mr), .Branch_taken_EX(br),
    .DMem_req_Mem(req), .DMem_ack(ack),
    .en_PC(en_PC), .en_IFID(en_IFID), .en_IDEX(en_IDEX), .en_EXMem(en_EXMem), .en_MemWB(en_MemWB),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .state_out(state_out), .bus_err(bus_err), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] a1, input logic [4:0] a2, input logic v1, input logic v2,
                      input logic [4:0] d, input logic m, input logic b, input logic q, input logic k,
                      input logic [6:0] ec, input logic [1:0] es, input logic ee, input string tag);
    exp_t e;
    rst_HSC = r; rs1 = a1; rs2 = a2; u1 = v1; u2 = v2; rd = d; mr = m; br = b; req = q; ack = k;
    e.ctrl = ec; e.st = es; e.err = ee; e.stall = exp_stall; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, "_ctrl"}, {25'd0, en_PC, en_IFID, en_IDEX, en_EXMem, en_MemWB, flush_IFID, flush_IDEX}, {25'd0, e.ctrl});
    chk({e.tag, "_state"}, {30'd0, state_out}, {30'd0, e.st});
    chk({e.tag, "_buserr"}, {31'd0, bus_err}, {31'd0, e.err});
    chk({e.tag, "_stallcnt"}, stall_cnt, e.stall);
    if (r) exp_stall = 0;
    else if (!ec[6]) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic b, input logic q, input logic k,
                     input logic [6:0] ec, input logic [1:0] es, input logic ee, input string tag);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, b, q, k, ec, es, ee, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_HSC = 1'b1; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; rd = 0; mr = 0; br = 0; req = 0; ack = 0;
    @(posedge clk);
    #1;
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, FRZ, 2'd0, 1'b0, "reset");
    for (int i = 0; i < 20; i++)
      step(1'b0, 5'(i), 5'(i + 1), 1'b1, 1'b1, 5'(i + 3), 1'b0, 1'b0, 1'(i % 2), 1'b1, NORM, 2'd0, 1'b0, "alu");
    step(1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, LU,   2'd0, 1'b0, "lu_rs2");
    step(1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, NORM, 2'd0, 1'b0, "lu_after");
    step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, NORM, 2'd0, 1'b0, "lu_x0");
    step(1'b0, 5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, NORM, 2'd0, 1'b0, "lu_unused");
    step(1'b0, 5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, LU,   2'd0, 1'b0, "lu_rs1");
    step(1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, BR,   2'd0, 1'b0, "br_over_lu");
    mem(1'b0, 1'b1, 1'b0, FRZ, 2'd0, 1'b0, "w4_c1");
    for (int i = 0; i < 3; i++) mem(1'b0, 1'b1, 1'b0, FRZ, 2'd1, 1'b0, "w4_wait");
    mem(1'b0, 1'b1, 1'b1, NORM, 2'd1, 1'b0, "w4_release");
    mem(1'b0, 1'b0, 1'b1, NORM, 2'd0, 1'b0, "w4_after");
    mem(1'b0, 1'b1, 1'b0, FRZ, 2'd0, 1'b0, "w15_c1");
    for (int i = 2; i <= 15; i++) mem(1'b0, 1'b1, 1'b0, FRZ, 2'd1, 1'b0, "w15_wait");
    mem(1'b0, 1'b1, 1'b1, NORM, 2'd1, 1'b0, "w15_release");
    mem(1'b0, 1'b0, 1'b1, NORM, 2'd0, 1'b0, "w15_after");
    mem(1'b1, 1'b1, 1'b0, FRZ, 2'd0, 1'b0, "wbr_c1");
    for (int i = 2; i <= 14; i++) mem(1'b1, 1'b1, 1'b0, FRZ, 2'd1, 1'b0, "wbr_wait");
    mem(1'b1, 1'b1, 1'b1, BR, 2'd1, 1'b0, "wbr_release");
    mem(1'b0, 1'b0, 1'b1, NORM, 2'd0, 1'b0, "wbr_after");
    mem(1'b0, 1'b1, 1'b0, FRZ, 2'd0, 1'b0, "to_c1");
    for (int i = 2; i <= 16; i++) mem(1'b0, 1'b1, 1'b0, FRZ, 2'd1, 1'b0, "to_wait");
    mem(1'b0, 1'b1, 1'b0, FRZ, 2'd2, 1'b1, "to_err");
    mem(1'b0, 1'b1, 1'b1, FRZ, 2'd2, 1'b1, "err_ack");
    mem(1'b1, 1'b0, 1'b1, FRZ, 2'd2, 1'b1, "err_br");
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, FRZ, 2'd2, 1'b1, "err_reset");
    mem(1'b0, 1'b0, 1'b1, NORM, 2'd0, 1'b0, "post_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
